serial_byte_deserializer: RTL and testbench

Deserialiser feeding the 8-bit bit-reversal stage. It collects framed serial bits into a WIDTH-bit word and presents it on a valid/ready output port. The serial side cannot be stalled, so output back-pressure produces a sticky overrun flag instead of a stall. A mid-word frame marker discards the partial word and starts a new one (resync).

---
 rtl/serial_byte_deserializer.sv | 72 +++++++
 tb/tb_serial_byte_deserializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_byte_deserializer.sv
// serial_byte_deserializer: collects framed serial bits into a word on a valid/ready port, flagging overrun and resync
module serial_byte_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     frame_start,
  input  logic                     out_ready,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  output logic                     overrun,
  output logic                     frame_err,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n, seed, sh, data_n;
  logic [CW-1:0] cnt_n;
  logic done, load, ferr_ev, valid_n, ovr_n, ferr_n;
  always_comb begin
    seed = MSB_FIRST ? {{(WIDTH-1){1'b0}}, ser_in} : {ser_in, {(WIDTH-1){1'b0}}};
    sh = MSB_FIRST ? {sr[WIDTH-2:0], ser_in} : {ser_in, sr[WIDTH-1:1]};
    state_n = state;
    sr_n = sr;
    cnt_n = bit_cnt;
    done = 1'b0;
    ferr_ev = 1'b0;
    if (ser_valid) begin
      if (frame_start) begin
        ferr_ev = state == SHIFT;
        sr_n = seed;
        cnt_n = CW'(1);
        state_n = SHIFT;
      end else if (state == SHIFT) begin
        sr_n = sh;
        done = bit_cnt == CW'(WIDTH - 1);
        cnt_n = done ? '0 : bit_cnt + 1'b1;
        state_n = done ? IDLE : SHIFT;
      end
    end
    // serial side never stalls: a word completing into a held output is dropped
    load = done && (!out_valid || out_ready);
    valid_n = load || (out_valid && !out_ready);
    data_n = load ? sh : data_out;
    ovr_n = (done && !load) || (overrun && !clr_err);
    ferr_n = ferr_ev || (frame_err && !clr_err);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      data_out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      bit_cnt <= cnt_n;
      data_out <= data_n;
      out_valid <= valid_n;
      overrun <= ovr_n;
      frame_err <= ferr_n;
    end
  end
endmodule

// File: tb/tb_serial_byte_deserializer.sv
// tb_serial_byte_deserializer: table, directed and random checks against a queue-based word model
module tb_serial_byte_deserializer;
  localparam int W = 8;
  localparam bit MSB = 1'b1;
  logic clk = 1'b0, rst = 1'b1;
  logic ser_in = 1'b0, ser_valid = 1'b0, frame_start = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
  logic [W-1:0] data_out;
  logic out_valid, overrun, frame_err;
  logic [$clog2(W)-1:0] bit_cnt;
  int tests = 0, fails = 0;

  serial_byte_deserializer #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_start(frame_start),
    .out_ready(out_ready), .clr_err(clr_err), .data_out(data_out), .out_valid(out_valid),
    .overrun(overrun), .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  logic q[$];
  logic m_active = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [W-1:0] m_data = '0;

  typedef struct {
    logic sv, fs, b, rdy, clr;
    logic [W-1:0] d;
    logic v, o, f;
    int c;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = '0;
  endtask

  task automatic check_model();
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("bit_cnt", 32'(bit_cnt), m_active ? q.size() : 0);
  endtask

  task automatic cyc(input logic sv, input logic fs, input logic b, input logic rdy, input logic clr);
    logic done, oev, fev;
    logic [W-1:0] w;
    ser_valid = sv; frame_start = fs; ser_in = b; out_ready = rdy; clr_err = clr;
    @(posedge clk);
    done = 1'b0; oev = 1'b0; fev = 1'b0; w = '0;
    if (sv) begin
      if (fs) begin
        fev = m_active;
        q.delete();
        q.push_back(b);
        m_active = 1'b1;
      end else if (m_active) q.push_back(b);
      if (m_active && q.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) w[MSB ? W-1-i : i] = q[i];
        q.delete();
        m_active = 1'b0;
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_data = w;
      m_valid = 1'b1;
    end else if (done) oev = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
    m_ovr = oev | (m_ovr & ~clr);
    m_ferr = fev | (m_ferr & ~clr);
    #1;
    check_model();
  endtask

  task automatic send(input logic [7:0] w, input logic rdy, input logic rdy_last, input int gap);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i == 0, w[7-i], i == 7 ? rdy_last : rdy, 1'b0);
      if (i < 7) for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, 32'(data_out), 0);
    chk({n, "_valid"}, 32'(out_valid), 0);
    chk({n, "_ovr"}, 32'(overrun), 0);
    chk({n, "_ferr"}, 32'(frame_err), 0);
    chk({n, "_cnt"}, 32'(bit_cnt), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    vec_t tbl[10];
    logic [7:0] r;
    tbl = '{
      '{1,1,1,1,0, 8'h00,0,0,0,1},
      '{1,0,0,1,0, 8'h00,0,0,0,2},
      '{1,0,1,1,0, 8'h00,0,0,0,3},
      '{1,0,1,1,0, 8'h00,0,0,0,4},
      '{1,0,0,1,0, 8'h00,0,0,0,5},
      '{1,0,0,1,0, 8'h00,0,0,0,6},
      '{1,0,1,1,0, 8'h00,0,0,0,7},
      '{1,0,1,1,0, 8'hB3,1,0,0,0},
      '{0,0,0,1,0, 8'hB3,0,0,0,0},
      '{1,0,1,1,0, 8'hB3,0,0,0,0}
    };
    #3 chk_zero("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].sv, tbl[i].fs, tbl[i].b, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("t1_data_%0d", i), 32'(data_out), 32'(tbl[i].d));
      chk($sformatf("t1_valid_%0d", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("t1_ovr_%0d", i), 32'(overrun), 32'(tbl[i].o));
      chk($sformatf("t1_ferr_%0d", i), 32'(frame_err), 32'(tbl[i].f));
      chk($sformatf("t1_cnt_%0d", i), 32'(bit_cnt), tbl[i].c);
      if (i == 7) begin
        for (int k = 0; k < 8; k++) r[k] = data_out[7-k];
        chk("t1_reversed", 32'(r), 32'hCD);
      end
    end

    send(8'h01, 1'b1, 1'b1, 3);
    chk("t2_data", 32'(data_out), 32'h01);
    chk("t2_flags", 32'({overrun, frame_err}), 0);

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 0);
    send(8'h80, 1'b0, 1'b0, 0);
    chk("t3_data", 32'(data_out), 32'hFF);
    chk("t3_ovr", 32'(overrun), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_valid_drop", 32'(out_valid), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovr_clr", 32'(overrun), 0);

    send(8'hFF, 1'b0, 1'b0, 0);
    chk("t4_first", 32'(data_out), 32'hFF);
    send(8'h80, 1'b0, 1'b1, 0);
    chk("t4_valid", 32'(out_valid), 1);
    chk("t4_data", 32'(data_out), 32'h80);
    chk("t4_ovr", 32'(overrun), 0);

    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
    send(8'h5A, 1'b1, 1'b1, 0);
    chk("t5_ferr", 32'(frame_err), 1);
    chk("t5_data", 32'(data_out), 32'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_ferr_clr", 32'(frame_err), 0);

    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_cnt_ignored", 32'(bit_cnt), 0);

    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
